// File: rtl/rv32i_pkg.sv
// Shared RV32I control-path definitions: next-PC select encodings, fetch
// sequencer states, instruction field positions and an alignment helper.
package rv32i_pkg;

  typedef enum logic [1:0] {
    NS_PC4  = 2'b00,
    NS_JALR = 2'b01,
    NS_JAL  = 2'b10,
    NS_BR   = 2'b11
  } next_sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    ERROR = 2'b10
  } fetch_state_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int FUNC7_BIT  = 30;

  // Only the two low address bits matter for word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection: sequential, jalr, jal and conditional branch targets,
// plus the word-alignment flag for the selected target.
module next_pc_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      next_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] npc,
  output logic            npc_misalign
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_pc;

  // Adders wrap modulo 2^XLEN; jalr drops bit 0 of rs1+imm.
  assign seq_pc  = pc + XLEN'(4);
  assign rel_pc  = pc + imm;
  assign jalr_pc = alu_result & ~XLEN'(1);

  always_comb begin
    npc = seq_pc;
    case (next_sel)
      NS_PC4:  npc = seq_pc;
      NS_JALR: npc = jalr_pc;
      NS_JAL:  npc = rel_pc;
      NS_BR: begin
        if (br_taken) begin
          npc = rel_pc;
        end else begin
          npc = seq_pc;
        end
      end
      default: npc = seq_pc;
    endcase
  end

  assign npc_misalign = is_misaligned(npc[1:0]);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch / PC sequencer: one instruction in flight,
// FETCH -> EXEC -> FETCH, with a sticky ERROR state on a misaligned target.
module fetch_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
  output logic            instr_valid,
  input  logic            instr_done,
  input  logic [1:0]      next_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  output logic            misalign
);

  fetch_state_e    state;
  logic [XLEN-1:0] npc;
  logic            npc_misalign;

  next_pc_gen #(
    .XLEN(XLEN)
  ) u_next_pc_gen (
    .pc          (pc),
    .next_sel    (next_sel),
    .br_taken    (br_taken),
    .alu_result  (alu_result),
    .imm         (imm),
    .npc         (npc),
    .npc_misalign(npc_misalign)
  );

  assign imem_addr = pc;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign func3     = instr[FUNC3_MSB:FUNC3_LSB];
  assign func7     = instr[FUNC7_BIT];

  // imem_req / instr_valid are registered alongside the state so they
  // always reflect the state being entered; ack/done only act in their own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= XLEN'(RESET_PC);
      instr       <= {XLEN{1'b0}};
      misalign    <= 1'b0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (instr_done) begin
            instr_valid <= 1'b0;
            if (npc_misalign) begin
              state    <= ERROR;
              misalign <= 1'b1;
              imem_req <= 1'b0;
            end else begin
              state    <= FETCH;
              pc       <= npc;
              imem_req <= 1'b1;
            end
          end else begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ERROR: begin
          misalign    <= 1'b1;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely and flag it.
          state       <= ERROR;
          misalign    <= 1'b1;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; outputs sampled on the
// falling clock edge, inputs changed right after sampling.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        instr_valid;
  logic        instr_done = 1'b0;
  logic [1:0]  next_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] imm = 32'h0;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7), .instr_valid(instr_valid),
    .instr_done(instr_done), .next_sel(next_sel), .br_taken(br_taken),
    .alu_result(alu_result), .imm(imm), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Stimulus only: one zero-wait instruction from FETCH back to FETCH.
  task automatic run_instr(input logic [31:0] rd, input logic [1:0] sel, input logic br,
                           input logic [31:0] alu, input logic [31:0] im);
    imem_ack = 1'b1; imem_rdata = rd;
    @(negedge clk);
    imem_ack = 1'b0; instr_done = 1'b1; next_sel = sel; br_taken = br;
    alu_result = alu; imm = im;
    @(negedge clk);
    instr_done = 1'b0; next_sel = 2'b00; br_taken = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req got %0b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %0b exp 0", misalign); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req_after_reset got %0b exp 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0021;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b exp 1", instr_valid); end
    n_cmp++; if (opcode !== 7'b0100001) begin n_err++; $display("FAIL basic_opcode got %b exp 0100001", opcode); end
    n_cmp++; if (func3 !== 3'd0) begin n_err++; $display("FAIL basic_func3 got %0d exp 0", func3); end
    n_cmp++; if (func7 !== 1'b0) begin n_err++; $display("FAIL basic_func7 got %0b exp 0", func7); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_exec got %0b exp 0", imem_req); end
    instr_done = 1'b1; next_sel = 2'b00;
    @(negedge clk);
    instr_done = 1'b0;
    n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_next_addr got %h exp 4", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %0b exp 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req_refetch got %0b exp 1", imem_req); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL wait_hold cyc %0d req %0b addr %h valid %0b exp 1/4/0", i, imem_req, imem_addr, instr_valid);
      end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h13) begin
      n_err++; $display("FAIL wait_capture valid %0b instr %h exp 1/00000013", instr_valid, instr);
    end
    instr_done = 1'b1; next_sel = 2'b10; imm = 32'h0000_00FC;
    @(negedge clk);
    instr_done = 1'b0;
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL wait_jal got %h exp 00000100", pc); end
  endtask

  task automatic test_branch();
    run_instr(32'h13, 2'b11, 1'b1, 32'h0, 32'hFFFF_FFF8);
    n_cmp++; if (pc !== 32'hF8) begin n_err++; $display("FAIL br_taken got %h exp 000000f8", pc); end
    run_instr(32'h13, 2'b10, 1'b0, 32'h0, 32'h8);
    run_instr(32'h13, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFF8);
    n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL br_not_taken got %h exp 00000104", pc); end
    run_instr(32'h13, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC);
    run_instr(32'h13, 2'b10, 1'b0, 32'h0, 32'h20);
    n_cmp++; if (pc !== 32'h120) begin n_err++; $display("FAIL jal_fwd got %h exp 00000120", pc); end
    run_instr(32'h13, 2'b00, 1'b1, 32'h0, 32'h40);
    n_cmp++; if (pc !== 32'h124) begin n_err++; $display("FAIL pc4_ignores_br got %h exp 00000124", pc); end
  endtask

  task automatic test_wrap_and_jalr();
    run_instr(32'h13, 2'b10, 1'b0, 32'h0, 32'hFFFF_FED8);
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got %h exp fffffffc", pc); end
    run_instr(32'h13, 2'b00, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap got %h exp 0", pc); end
    run_instr(32'h13, 2'b01, 1'b0, 32'h201, 32'h0);
    n_cmp++; if (pc !== 32'h200 || misalign !== 1'b0) begin
      n_err++; $display("FAIL jalr_clear_bit0 pc %h misalign %0b exp 00000200/0", pc, misalign);
    end
  endtask

  task automatic test_spurious();
    instr_done = 1'b1; next_sel = 2'b10; imm = 32'h40;
    @(negedge clk);
    instr_done = 1'b0;
    n_cmp++; if (pc !== 32'h200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL spurious_done pc %h req %0b valid %0b exp 00000200/1/0", pc, imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033; instr_done = 1'b1;
    @(negedge clk);
    instr_done = 1'b0; imem_rdata = 32'h0000_0067;
    n_cmp++; if (pc !== 32'h200 || instr !== 32'h33 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL ack_and_done pc %h instr %h valid %0b exp 00000200/00000033/1", pc, instr, instr_valid);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++; if (instr !== 32'h33 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL ack_in_exec instr %h valid %0b exp 00000033/1", instr, instr_valid);
    end
    instr_done = 1'b1; next_sel = 2'b00;
    @(negedge clk);
    instr_done = 1'b0;
    n_cmp++; if (pc !== 32'h204) begin n_err++; $display("FAIL spurious_resume got %h exp 00000204", pc); end
  endtask

  task automatic test_misalign();
    run_instr(32'h67, 2'b01, 1'b0, 32'h203, 32'h0);
    n_cmp++; if (misalign !== 1'b1 || pc !== 32'h204 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL misalign_enter mis %0b pc %h req %0b valid %0b exp 1/00000204/0/0", misalign, pc, imem_req, instr_valid);
    end
    imem_ack = 1'b1; instr_done = 1'b1; next_sel = 2'b00;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0; instr_done = 1'b0;
    n_cmp++; if (misalign !== 1'b1 || pc !== 32'h204 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL misalign_sticky mis %0b pc %h req %0b valid %0b exp 1/00000204/0/0", misalign, pc, imem_req, instr_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (misalign !== 1'b0 || pc !== 32'h0) begin
      n_err++; $display("FAIL error_cleared mis %0b pc %h exp 0/0", misalign, pc);
    end
    run_instr(32'h13, 2'b10, 1'b0, 32'h0, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'h0000_00EF;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h40) begin
      n_err++; $display("FAIL pre_reset_exec valid %0b pc %h exp 1/00000040", instr_valid, pc);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || misalign !== 1'b0) begin
      n_err++; $display("FAIL async_reset pc %h instr %h valid %0b req %0b mis %0b exp 0/0/0/1/0", pc, instr, instr_valid, imem_req, misalign);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL post_reset_fetch req %0b addr %h exp 1/0", imem_req, imem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++; if (instr !== 32'h93 || instr_valid !== 1'b1 || pc !== 32'h0) begin
      n_err++; $display("FAIL outstanding_ack instr %h valid %0b pc %h exp 00000093/1/0", instr, instr_valid, pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_branch();
    test_wrap_and_jalr();
    test_spurious();
    test_misalign();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
